// File: rtl/reg_file.sv
// Register file: 2 combinational read ports, 1 write port, x0 hardwired to zero, registered a0 mirror.
// Latency: reads 0 cycles, writes visible next cycle, a0 updates on the write edge; no backpressure, always ready.
module reg_file #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int BYPASS        = 1,
    parameter int A0_INDEX      = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] AD1,
    input  logic [ADDRESS_WIDTH-1:0] AD2,
    input  logic [ADDRESS_WIDTH-1:0] AD3,
    input  logic                     WE3,
    input  logic [DATA_WIDTH-1:0]    WD3,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    output logic [DATA_WIDTH-1:0]    a0
);

    localparam int                     NUM_REGS = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR = ADDRESS_WIDTH'(A0_INDEX);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] a0_next;

    assign wr_en = WE3 && (AD3 != '0);

    // a0 tracks the post-edge value of its register, so a same-edge write is forwarded.
    always_comb begin
        a0_next = regs[A0_ADDR];
        if (wr_en && (AD3 == A0_ADDR)) begin
            a0_next = WD3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            a0 <= '0;
        end else begin
            if (wr_en) begin
                regs[AD3] <= WD3;
            end
            a0 <= a0_next;
        end
    end

    always_comb begin
        RD1 = '0;
        if (AD1 != '0) begin
            if ((BYPASS != 0) && WE3 && (AD3 == AD1)) begin
                RD1 = WD3;
            end else begin
                RD1 = regs[AD1];
            end
        end
    end

    always_comb begin
        RD2 = '0;
        if (AD2 != '0) begin
            if ((BYPASS != 0) && WE3 && (AD3 == AD2)) begin
                RD2 = WD3;
            end else begin
                RD2 = regs[AD2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: bypass and non-bypass instances share stimulus and are checked against an array model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ad1, ad2, ad3;
    logic        we3;
    logic [31:0] wd3;
    logic [31:0] rd1_b, rd2_b, a0_b;
    logic [31:0] rd1_n, rd2_n, a0_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [32];
    logic [31:0] model_a0;

    always #5 clk = ~clk;

    reg_file #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .BYPASS(1), .A0_INDEX(10)) u_byp (
        .clk(clk), .rst_n(rst_n), .AD1(ad1), .AD2(ad2), .AD3(ad3), .WE3(we3), .WD3(wd3),
        .RD1(rd1_b), .RD2(rd2_b), .a0(a0_b)
    );

    reg_file #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .BYPASS(0), .A0_INDEX(10)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .AD1(ad1), .AD2(ad2), .AD3(ad3), .WE3(we3), .WD3(wd3),
        .RD1(rd1_n), .RD2(rd2_n), .a0(a0_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] addr, input bit byp);
        if (addr == 0) return 32'h0;
        if (byp && we3 && ad3 == addr) return wd3;
        return model[addr];
    endfunction

    // Advance one edge and apply the architectural effect of that edge to the model.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            foreach (model[i]) model[i] = 32'h0;
        end else if (we3 && ad3 != 0) begin
            model[ad3] = wd3;
        end
        model_a0 = model[10];
        #1;
    endtask

    task automatic check_reads(input string tag);
        #1;
        chk({tag, ".rd1_byp"},   rd1_b, exp_rd(ad1, 1'b1));
        chk({tag, ".rd2_byp"},   rd2_b, exp_rd(ad2, 1'b1));
        chk({tag, ".rd1_nobyp"}, rd1_n, exp_rd(ad1, 1'b0));
        chk({tag, ".rd2_nobyp"}, rd2_n, exp_rd(ad2, 1'b0));
        chk({tag, ".a0_byp"},    a0_b,  model_a0);
        chk({tag, ".a0_nobyp"},  a0_n,  model_a0);
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        we3 = 1'b1; ad3 = a; wd3 = d;
        step();
        we3 = 1'b0;
    endtask

    initial begin
        foreach (model[i]) model[i] = 32'hx;
        model_a0 = 32'hx;

        // Reset held two edges with a conflicting write pending.
        rst_n = 1'b0; we3 = 1'b1; ad3 = 5'd5; wd3 = 32'hDEADBEEF; ad1 = 5'd5; ad2 = 5'd0;
        step();
        step();
        rst_n = 1'b1; we3 = 1'b0;
        check_reads("reset");
        chk("reset.rd1_x5", rd1_b, 32'h0);
        for (int i = 0; i < 32; i++) begin
            ad1 = 5'(i); ad2 = 5'(31 - i);
            check_reads("reset_sweep");
        end

        write(5'd3, 32'h00000007);
        write(5'd4, 32'hFFFFFFF9);
        ad1 = 5'd3; ad2 = 5'd4;
        check_reads("wr_rd");
        chk("wr_rd.rd1_lit", rd1_n, 32'h00000007);
        chk("wr_rd.rd2_lit", rd2_n, 32'hFFFFFFF9);

        we3 = 1'b1; ad3 = 5'd0; wd3 = 32'h12345678; ad1 = 5'd0; ad2 = 5'd0;
        check_reads("x0_before");
        step();
        we3 = 1'b0;
        check_reads("x0_after");
        chk("x0_after.rd1_lit", rd1_b, 32'h0);

        write(5'd6, 32'h11);
        we3 = 1'b1; ad3 = 5'd6; wd3 = 32'h22; ad1 = 5'd6; ad2 = 5'd6;
        check_reads("bypass_same");
        chk("bypass_same.byp_lit",   rd1_b, 32'h22);
        chk("bypass_same.nobyp_lit", rd2_n, 32'h11);
        step();
        we3 = 1'b0;
        check_reads("bypass_after");
        chk("bypass_after.nobyp_lit", rd1_n, 32'h22);

        write(5'd10, 32'h000000FF);
        check_reads("a0_write");
        chk("a0_write.lit", a0_b, 32'h000000FF);
        rst_n = 1'b0; we3 = 1'b1; ad3 = 5'd10; wd3 = 32'hAA;
        step();
        rst_n = 1'b1; we3 = 1'b0; ad1 = 5'd10; ad2 = 5'd6;
        check_reads("a0_reset");
        chk("a0_reset.a0_lit",  a0_n,  32'h0);
        chk("a0_reset.rd1_lit", rd1_b, 32'h0);

        for (int i = 1; i < 32; i++) write(5'(i), 32'(i + 1));
        for (int i = 0; i < 32; i++) begin
            ad1 = 5'(i); ad2 = 5'(31 - i);
            check_reads("sweep");
            chk("sweep.rd1_lit", rd1_b, (i == 0) ? 32'h0 : 32'(i + 1));
            chk("sweep.rd2_lit", rd2_n, (i == 31) ? 32'h0 : 32'(32 - i));
        end

        // Random traffic, biased toward read/write address collisions and x10.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            we3   = ($urandom_range(0, 3) != 0);
            ad3   = ($urandom_range(0, 4) == 0) ? 5'd10 : 5'($urandom);
            wd3   = $urandom;
            ad1   = ($urandom_range(0, 2) == 0) ? ad3 : 5'($urandom);
            ad2   = ($urandom_range(0, 2) == 0) ? ad3 : 5'($urandom);
            if (rst_n) check_reads("rand_pre");
            step();
            rst_n = 1'b1; we3 = 1'b0;
            check_reads("rand_post");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
